// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_unit
//  Description : Hazard, forwarding, flush and halt controller for an
//                N-stage in-order pipeline. A shift scoreboard holds one
//                {valid, rd, is_load} entry per slot after ID. Slot 0 is
//                ID/EX, slot EX_STAGES is EX/MEM and slot DEPTH-1 is MEM/WB.
//                Optional build macro PIPE_CTRL_PERF_EN adds saturating
//                stall/flush performance counters (stall_cnt, flush_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter  int REG_ADDR_W = 4,
    parameter  int EX_STAGES  = 2,
    parameter  int BR_SLOT    = 1,
    localparam int DEPTH      = EX_STAGES + 2,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_jump,
    input  logic                  id_halt,
    input  logic                  br_taken,
    output logic                  stall,
    output logic                  flush_if,
    output logic [DEPTH-1:0]      flush_mask,
    output logic [SEL_W-1:0]      fwd_a,
    output logic [SEL_W-1:0]      fwd_b,
    output logic                  draining,
    output logic                  halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    // Slot indices and forward codes share the SEL_W encoding.
    localparam logic [SEL_W-1:0] c_ex_stages = SEL_W'(EX_STAGES);
    localparam logic [SEL_W-1:0] c_last_slot = SEL_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0] c_wb_bypass = SEL_W'(DEPTH);
    // Slots younger than the resolving branch get squashed.
    localparam logic [DEPTH-1:0] c_br_mask   = DEPTH'((1 << BR_SLOT) - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_draining;
    logic                  r_halted;

    logic [DEPTH-1:0]      r_sb_valid;
    logic [DEPTH-1:0]      r_sb_load;
    logic [REG_ADDR_W-1:0] r_sb_rd [DEPTH];

    logic                  w_use_a;
    logic                  w_use_b;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic                  w_ld_a;
    logic                  w_ld_b;
    logic [SEL_W-1:0]      w_k_a;
    logic [SEL_W-1:0]      w_k_b;
    logic                  w_load_use;
    logic                  w_stall_req;
    logic                  w_push;

    // A source only participates when ID is real, reads it, and it is not r0.
    assign w_use_a = id_valid & id_use_rs1 & (id_rs1 != '0);
    assign w_use_b = id_valid & id_use_rs2 & (id_rs2 != '0);

    // Youngest-match search: scanning oldest to youngest lets the lowest slot win.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        w_k_a   = '0;
        w_k_b   = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (w_use_a && r_sb_valid[s] && (r_sb_rd[s] == id_rs1)) begin
                w_hit_a = 1'b1;
                w_ld_a  = r_sb_load[s];
                w_k_a   = SEL_W'(s);
            end
            if (w_use_b && r_sb_valid[s] && (r_sb_rd[s] == id_rs2)) begin
                w_hit_b = 1'b1;
                w_ld_b  = r_sb_load[s];
                w_k_b   = SEL_W'(s);
            end
        end
    end

    // A load still inside EX cannot supply data in time for the next capture.
    assign w_load_use = (w_hit_a & w_ld_a & (w_k_a < c_ex_stages)) |
                        (w_hit_b & w_ld_b & (w_k_b < c_ex_stages));

    assign w_stall_req = ((r_state == ST_RUN) & w_load_use) | (r_state == ST_DRAIN);

    // A taken branch overrides any stall except a completed halt.
    assign stall = (r_state == ST_HALTED) | (w_stall_req & ~br_taken);

    assign flush_if   = br_taken | (id_jump & id_valid & ~stall);
    assign flush_mask = br_taken ? c_br_mask : '0;

    // Forward select: slot k feeds EX1 through stage k+1; MEM/WB uses the WB bypass.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        if (!w_load_use) begin
            if (w_hit_a) begin
                fwd_a = (w_k_a == c_last_slot) ? c_wb_bypass : (w_k_a + SEL_W'(1));
            end
            if (w_hit_b) begin
                fwd_b = (w_k_b == c_last_slot) ? c_wb_bypass : (w_k_b + SEL_W'(1));
            end
        end
    end

    // Only non-zero writers that actually leave ID occupy a scoreboard slot.
    assign w_push = id_valid & id_reg_write & (id_rd != '0) &
                    ~stall & ~br_taken & ~id_halt;

    // Scoreboard shifts every cycle; squashed slots become bubbles as they move.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb_valid <= '0;
            r_sb_load  <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                r_sb_rd[s] <= '0;
            end
        end else begin
            r_sb_valid[0] <= w_push;
            r_sb_load[0]  <= w_push & id_mem_read;
            r_sb_rd[0]    <= w_push ? id_rd : '0;
            for (int s = 1; s < DEPTH; s++) begin
                r_sb_valid[s] <= r_sb_valid[s-1] & ~flush_mask[s-1];
                r_sb_load[s]  <= r_sb_load[s-1];
                r_sb_rd[s]    <= r_sb_rd[s-1];
            end
        end
    end

    // Halt FSM: drain in-flight work, then freeze until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_draining <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (id_halt && id_valid && !stall && !br_taken) begin
                        r_state    <= ST_DRAIN;
                        r_draining <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (br_taken) begin
                        r_state    <= ST_RUN;
                        r_draining <= 1'b0;
                    end else if (r_sb_valid == '0) begin
                        r_state    <= ST_HALTED;
                        r_draining <= 1'b0;
                        r_halted   <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_draining <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign draining = r_draining;
    assign halted   = r_halted;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating counters: RUN-state stall cycles and taken-branch cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state == ST_RUN) && stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (br_taken && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
